// File: rtl/bp_upd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bp_upd_ctrl_pkg
// Shared definitions for the branch-predictor update controller:
//   - controller FSM state encoding
//   - default table-clear sweep size (entries and index width)
//   - update-entry layout as stored in the update FIFO (71 bits)
// ---------------------------------------------------------------------------
package bp_upd_ctrl_pkg;

    localparam int CLR_ENTRIES_DEF = 64;
    localparam int CLR_BIT_DEF     = 6;

    localparam int PC_W        = 32;
    localparam int UPD_FLAGS_W = 4;
    localparam int UPD_PAD_W   = 3;
    localparam int UPD_ENTRY_W = 2 * PC_W + UPD_FLAGS_W + UPD_PAD_W;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } upd_state_e;

    // rsvd is spare room in the entry; it is written as zero and never read.
    typedef struct packed {
        logic [UPD_PAD_W-1:0] rsvd;
        logic [PC_W-1:0]      pc;
        logic [PC_W-1:0]      target;
        logic                 branched;
        logic                 answ;
        logic                 answ_bht;
        logic                 answ_ghr;
    } upd_entry_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// ---------------------------------------------------------------------------
// bp_upd_fifo
// Synchronous update queue with a registered head entry.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : enqueue request and entry (ignored when full)
//   pop           : dequeue request (ignored when empty)
//   head          : current head entry, driven from a register
//   empty, full   : occupancy flags (pointers carry one extra wrap bit)
// ---------------------------------------------------------------------------
module bp_upd_fifo
    import bp_upd_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UPD_ENTRY_W-1:0] wdata,
    output logic [UPD_ENTRY_W-1:0] head,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]            wr_ptr_q;
    logic [AW:0]            rd_ptr_q;
    logic [AW:0]            rd_ptr_nxt;
    logic [AW:0]            occ;
    logic [UPD_ENTRY_W-1:0] mem_q [DEPTH];
    logic [UPD_ENTRY_W-1:0] head_q;
    logic                   push_ok;
    logic                   pop_ok;
    logic                   last_one;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign rd_ptr_nxt = rd_ptr_q + PTR_ONE;
    assign occ        = wr_ptr_q - rd_ptr_q;
    assign last_one   = (occ == PTR_ONE);
    assign head       = head_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    // head_q always mirrors the oldest valid entry. When the queue is empty,
    // or the last entry leaves while a new one arrives, the incoming entry
    // bypasses storage straight into the head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            if (empty && push_ok) begin
                head_q <= wdata;
            end else if (pop_ok) begin
                if (!last_one) begin
                    head_q <= mem_q[rd_ptr_nxt[AW-1:0]];
                end else if (push_ok) begin
                    head_q <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/bp_upd_ctrl.sv
// ---------------------------------------------------------------------------
// bp_upd_ctrl
// Branch-predictor update controller: queues resolved branches from EX,
// retires them into the predictor write port, and sequences full table
// clears after reset and on flush requests.
//   clk, rst                      : clock, synchronous active-high reset
//   ex_valid/ex_ready, ex_*       : resolved-branch offer from EX
//   flush_req                     : one-cycle request for a full clear
//   upd_valid/upd_ready, upd_*    : head-entry update to the predictor
//   clr_we, clr_idx               : table-clear write strobe and index
//   pred_en                       : IF1 may use predictions
//   busy                          : controller not in RUN
//   mispred_cnt, upd_cnt          : retired mispredictions / updates
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | post-reset sweep, clr_we over every table index
// ST_RUN   | normal operation, accept and retire updates
// ST_DRAIN | flush seen, retire queued updates, accept nothing
// ST_CLEAR | flush sweep, clr_we over every table index
// ---------------------------------------------------------------------------
module bp_upd_ctrl
    import bp_upd_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int CLR_ENTRIES = CLR_ENTRIES_DEF,
    parameter int CLR_BIT     = CLR_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_target,
    input  logic               ex_taken,
    input  logic               ex_answ,
    input  logic               ex_answ_bht,
    input  logic               ex_answ_ghr,
    input  logic               flush_req,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [31:0]        upd_pc,
    output logic [31:0]        upd_wtarget,
    output logic               upd_branched,
    output logic               upd_answ,
    output logic               upd_answ_bht,
    output logic               upd_answ_ghr,
    output logic               clr_we,
    output logic [CLR_BIT-1:0] clr_idx,
    output logic               pred_en,
    output logic               busy,
    output logic [31:0]        mispred_cnt,
    output logic [31:0]        upd_cnt
);

    upd_state_e         state_q;
    upd_state_e         state_d;
    logic [CLR_BIT-1:0] clr_idx_q;
    logic               clr_last;
    logic               run;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    upd_entry_t         ex_entry;
    upd_entry_t         head_e;
    logic [31:0]        upd_cnt_q;
    logic [31:0]        mispred_cnt_q;
    logic               unused_rsvd;

    assign ex_entry = '{rsvd:     '0,
                        pc:       ex_pc,
                        target:   ex_target,
                        branched: ex_taken,
                        answ:     ex_answ,
                        answ_bht: ex_answ_bht,
                        answ_ghr: ex_answ_ghr};

    assign run      = (state_q == ST_RUN);
    assign ex_ready = run && !fifo_full && !flush_req;
    assign push     = ex_valid && ex_ready;
    assign pop      = !fifo_empty && upd_ready &&
                      (run || (state_q == ST_DRAIN));

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (ex_entry),
        .head  (head_e),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign upd_valid    = !fifo_empty;
    assign upd_pc       = head_e.pc;
    assign upd_wtarget  = head_e.target;
    assign upd_branched = head_e.branched;
    assign upd_answ     = head_e.answ;
    assign upd_answ_bht = head_e.answ_bht;
    assign upd_answ_ghr = head_e.answ_ghr;
    assign unused_rsvd  = ^head_e.rsvd;

    assign clr_last = (clr_idx_q == CLR_BIT'(CLR_ENTRIES - 1));
    assign clr_idx  = clr_idx_q;
    assign pred_en  = run;
    assign busy     = !run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_INIT, ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // The sweep index returns to zero at the end of every sweep so the
    // next CLEAR starts from the bottom of the table.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx_q <= '0;
        end else if (clr_we) begin
            clr_idx_q <= clr_last ? '0 : clr_idx_q + CLR_BIT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else if (pop) begin
            upd_cnt_q <= upd_cnt_q + 32'd1;
            if (head_e.answ != head_e.branched) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign upd_cnt     = upd_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bp_upd_ctrl.sv
module tb_bp_upd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_answ;
    logic        ex_answ_bht;
    logic        ex_answ_ghr;
    logic        flush_req;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_wtarget;
    logic        upd_branched;
    logic        upd_answ;
    logic        upd_answ_bht;
    logic        upd_answ_ghr;
    logic        clr_we;
    logic [5:0]  clr_idx;
    logic        pred_en;
    logic        busy;
    logic [31:0] mispred_cnt;
    logic [31:0] upd_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tg;
        logic        br;
        logic        an;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    bp_upd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_target    (ex_target),
        .ex_taken     (ex_taken),
        .ex_answ      (ex_answ),
        .ex_answ_bht  (ex_answ_bht),
        .ex_answ_ghr  (ex_answ_ghr),
        .flush_req    (flush_req),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_wtarget  (upd_wtarget),
        .upd_branched (upd_branched),
        .upd_answ     (upd_answ),
        .upd_answ_bht (upd_answ_bht),
        .upd_answ_ghr (upd_answ_ghr),
        .clr_we       (clr_we),
        .clr_idx      (clr_idx),
        .pred_en      (pred_en),
        .busy         (busy),
        .mispred_cnt  (mispred_cnt),
        .upd_cnt      (upd_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] tg,
                         input logic tk, input logic an);
        ex_valid    = 1'b1;
        ex_pc       = pc;
        ex_target   = tg;
        ex_taken    = tk;
        ex_answ     = an;
        ex_answ_bht = tk;
        ex_answ_ghr = an;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            chk({tag, "_clr_we"}, 32'(clr_we), 32'd1);
            chk({tag, "_clr_idx"}, 32'(clr_idx), 32'(i));
            chk({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
            step();
        end
        chk({tag, "_pred_en"}, 32'(pred_en), 32'd1);
        chk({tag, "_clr_we_off"}, 32'(clr_we), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] tk_v;
        logic [3:0] an_v;
        int m_upd;
        int m_mis;

        rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_target = '0;
        ex_taken = 1'b0; ex_answ = 1'b0; ex_answ_bht = 1'b0; ex_answ_ghr = 1'b0;
        flush_req = 1'b0; upd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state, then INIT sweep
        chk("rst_pred_en", 32'(pred_en), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_upd_cnt", upd_cnt, 32'd0);
        chk("rst_mispred", mispred_cnt, 32'd0);
        sweep("init");
        chk("run_ex_ready", 32'(ex_ready), 32'd1);
        chk("run_busy", 32'(busy), 32'd0);

        // single push / retire with a misprediction
        upd_ready = 1'b1;
        offer(32'h1C00_0040, 32'h1C00_0100, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        chk("one_valid", 32'(upd_valid), 32'd1);
        chk("one_pc", upd_pc, 32'h1C00_0040);
        chk("one_tgt", upd_wtarget, 32'h1C00_0100);
        chk("one_br", 32'(upd_branched), 32'd1);
        chk("one_answ", 32'(upd_answ), 32'd0);
        chk("one_bht", 32'(upd_answ_bht), 32'd1);
        chk("one_ghr", 32'(upd_answ_ghr), 32'd0);
        chk("one_cnt_pre", upd_cnt, 32'd0);
        step();
        chk("one_valid_after", 32'(upd_valid), 32'd0);
        chk("one_mispred", mispred_cnt, 32'd1);
        chk("one_upd_cnt", upd_cnt, 32'd1);

        // back-to-back push and pop at occupancy 1
        for (int k = 0; k < 4; k++) begin
            if (k < 3) offer(32'h200 + 32'(4 * k), 32'h900, 1'b0, 1'b0);
            else ex_valid = 1'b0;
            if (k > 0) begin
                chk("b2b_valid", 32'(upd_valid), 32'd1);
                chk("b2b_pc", upd_pc, 32'h200 + 32'(4 * (k - 1)));
            end
            step();
        end
        chk("b2b_empty", 32'(upd_valid), 32'd0);
        chk("b2b_cnt", upd_cnt, 32'd4);

        // fill to full with the predictor stalled
        tk_v = 4'b0101;
        an_v = 4'b0011;
        upd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            offer(32'h300 + 32'(4 * k), 32'h800 + 32'(k), tk_v[k], an_v[k]);
            chk("full_acc", 32'(ex_ready), 32'd1);
            step();
        end
        chk("full_ready", 32'(ex_ready), 32'd0);
        chk("full_hold_pc", upd_pc, 32'h300);
        offer(32'hDEAD_0000, 32'h0, 1'b1, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("full_hold_pc2", upd_pc, 32'h300);
        upd_ready = 1'b1;
        #1;
        chk("full_pop_ready", 32'(ex_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", upd_pc, 32'h300 + 32'(4 * k));
            chk("drain_tgt", upd_wtarget, 32'h800 + 32'(k));
            chk("drain_br", 32'(upd_branched), 32'(tk_v[k]));
            step();
        end
        chk("full_no5th", 32'(upd_valid), 32'd0);
        chk("full_cnt", upd_cnt, 32'd8);
        chk("full_mispred", mispred_cnt, 32'd3);

        // flush with two entries queued
        upd_ready = 1'b0;
        offer(32'h400, 32'h0, 1'b1, 1'b1);
        step();
        offer(32'h404, 32'h0, 1'b1, 1'b1);
        step();
        ex_valid = 1'b0;
        upd_ready = 1'b1;
        flush_req = 1'b1;
        #1;
        chk("fl_ready", 32'(ex_ready), 32'd0);
        chk("fl_pc0", upd_pc, 32'h400);
        step();
        flush_req = 1'b0;
        chk("fl_busy", 32'(busy), 32'd1);
        chk("fl_pred_en", 32'(pred_en), 32'd0);
        chk("fl_pc1", upd_pc, 32'h404);
        chk("fl_clr_we", 32'(clr_we), 32'd0);
        step();
        chk("fl_empty", 32'(upd_valid), 32'd0);
        chk("fl_clr_we2", 32'(clr_we), 32'd0);
        step();
        sweep("clear");
        chk("fl_cnt", upd_cnt, 32'd10);
        chk("fl_mispred", mispred_cnt, 32'd3);

        // reset mid-drain discards queued entries
        upd_ready = 1'b0;
        offer(32'h500, 32'h0, 1'b1, 1'b0);
        step();
        offer(32'h504, 32'h0, 1'b1, 1'b0);
        step();
        ex_valid = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_valid", 32'(upd_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rd_flushed", 32'(upd_valid), 32'd0);
        chk("rd_upd_pc", upd_pc, 32'd0);
        chk("rd_cnt", upd_cnt, 32'd0);
        sweep("rd_init");

        // reset mid-clear restarts the sweep
        upd_ready = 1'b1;
        offer(32'h600, 32'h0, 1'b0, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        chk("rc_cnt_pre", upd_cnt, 32'd1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        for (int i = 0; i < 30; i++) step();
        chk("rc_idx30", 32'(clr_idx), 32'd30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rc_cnt", upd_cnt, 32'd0);
        chk("rc_mispred", mispred_cnt, 32'd0);
        sweep("rc_init");

        // random traffic against a queue model
        m_upd = 0;
        m_mis = 0;
        for (int c = 0; c < 2000; c++) begin
            logic v;
            logic r;
            int sz;
            ent_t e;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            e.pc = $urandom();
            e.tg = $urandom();
            e.br = 1'($urandom_range(0, 1));
            e.an = 1'($urandom_range(0, 1));
            upd_ready = r;
            if (v) offer(e.pc, e.tg, e.br, e.an);
            else ex_valid = 1'b0;
            sz = q.size();
            chk("rnd_ready", 32'(ex_ready), 32'(sz < 4));
            chk("rnd_valid", 32'(upd_valid), 32'(sz != 0));
            chk("rnd_excl", 32'(clr_we && upd_valid), 32'd0);
            if (sz != 0) begin
                chk("rnd_pc", upd_pc, q[0].pc);
                chk("rnd_tgt", upd_wtarget, q[0].tg);
                if (r) begin
                    m_upd++;
                    if (q[0].an != q[0].br) m_mis++;
                    void'(q.pop_front());
                end
            end
            if (v && sz < 4) q.push_back(e);
            step();
        end
        ex_valid = 1'b0;
        chk("rnd_upd_cnt", upd_cnt, 32'(m_upd));
        chk("rnd_mispred", mispred_cnt, 32'(m_mis));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
